keypad_entry: RTL and testbench

- Front-end stage that sits directly upstream of the room security controller.
- Takes four raw push-buttons (bit-0, bit-1, submit, cancel) and debounces each one.
- Assembles a 4-bit code MSB-first.
- On submit, drives `password_input[3:0]` and a one-cycle `enter` pulse into the controller.
- Rejects short entries and abandons stale partial entries after a timeout.

---
 rtl/keypad_entry.sv | 208 ++++++++++++++++++++
 tb/tb_keypad_entry.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// keypad_entry: debounced 4-button code entry feeding the room security controller.
// Optional post-submit input blanking is enabled by defining KEY_LOCKOUT_EN.
module keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ENTRY_TIMEOUT   = 1000,
    parameter int CODE_BITS       = 4,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 btn_zero,
    input  logic                 btn_one,
    input  logic                 btn_submit,
    input  logic                 btn_cancel,
    output logic [CODE_BITS-1:0] password_input,
    output logic                 enter,
    output logic [2:0]           digit_count,
    output logic                 entry_error,
    output logic                 busy
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(ENTRY_TIMEOUT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [2:0]    FULL    = 3'(CODE_BITS);

    // Reject parameter values the timing arithmetic cannot support
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (ENTRY_TIMEOUT < 2) begin : g_bad_to
        $error("ENTRY_TIMEOUT must be at least 2");
    end
    if (CODE_BITS != 4) begin : g_bad_bits
        $error("CODE_BITS must be 4");
    end
    if (LOCKOUT_CYCLES < 1) begin : g_bad_lk
        $error("LOCKOUT_CYCLES must be at least 1");
    end

`ifdef KEY_LOCKOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUBMIT, S_LOCKOUT} state_t;
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LW-1:0] LK_LAST = LW'(LOCKOUT_CYCLES - 1);
    logic [LW-1:0] r_lock;
    logic          r_busy;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUBMIT} state_t;
`endif

    // bit order: 3=cancel 2=submit 1=one 0=zero
    logic [3:0]    w_raw;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_level;
    logic [3:0]    r_level_d;
    logic [DW-1:0] r_db_cnt [4];
    logic [3:0]    w_evt;
    logic          w_cancel;
    logic          w_submit;
    logic          w_one;
    logic          w_zero;
    logic          w_bit;

    state_t                r_state;
    logic [CODE_BITS-1:0]  r_shift;
    logic [CODE_BITS-1:0]  r_pw;
    logic [2:0]            r_count;
    logic [TW-1:0]         r_tmo;
    logic                  r_enter;
    logic                  r_err;

    assign w_raw = {btn_cancel, btn_submit, btn_one, btn_zero};

    // Synchronize each button and accept a new level only after it holds steadily
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_evt    = r_level & ~r_level_d;
    assign w_cancel = w_evt[3];
    assign w_submit = w_evt[2] & ~w_evt[3];
    assign w_one    = w_evt[1] & ~|w_evt[3:2];
    assign w_zero   = w_evt[0] & ~|w_evt[3:1];
    assign w_bit    = w_one | w_zero;

    // Entry FSM with registered strobes and code output
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_pw    <= '0;
            r_count <= '0;
            r_tmo   <= '0;
            r_enter <= 1'b0;
            r_err   <= 1'b0;
`ifdef KEY_LOCKOUT_EN
            r_lock  <= '0;
            r_busy  <= 1'b0;
`endif
        end else begin
            r_enter <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cancel) begin
                        r_state <= S_IDLE;
                    end else if (w_submit) begin
                        r_err <= 1'b1;
                    end else if (w_bit) begin
                        r_shift <= {r_shift[CODE_BITS-2:0], w_one};
                        r_count <= 3'd1;
                        r_tmo   <= '0;
                        r_state <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (w_cancel) begin
                        r_shift <= '0;
                        r_count <= '0;
                        r_tmo   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_submit) begin
                        if (r_count == FULL) begin
                            r_state <= S_SUBMIT;
                        end else begin
                            r_err   <= 1'b1;
                            r_shift <= '0;
                            r_count <= '0;
                            r_tmo   <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_bit) begin
                        r_tmo <= '0;
                        if (r_count != FULL) begin
                            r_shift <= {r_shift[CODE_BITS-2:0], w_one};
                            r_count <= r_count + 3'd1;
                        end
                    end else if (r_tmo >= TO_LAST) begin
                        r_err   <= 1'b1;
                        r_shift <= '0;
                        r_count <= '0;
                        r_tmo   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_SUBMIT: begin
                    r_pw    <= r_shift;
                    r_enter <= 1'b1;
                    r_shift <= '0;
                    r_count <= '0;
`ifdef KEY_LOCKOUT_EN
                    r_lock  <= '0;
                    r_busy  <= 1'b1;
                    r_state <= S_LOCKOUT;
`else
                    r_state <= S_IDLE;
`endif
                end
`ifdef KEY_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (r_lock == LK_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_lock <= r_lock + 1'b1;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign password_input = r_pw;
    assign enter          = r_enter;
    assign digit_count    = r_count;
    assign entry_error    = r_err;
`ifdef KEY_LOCKOUT_EN
    assign busy = r_busy;
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_entry.sv
// tb_keypad_entry: directed stimulus with a queue scoreboard for enter/entry_error.
// Expectations for the lockout window follow KEY_LOCKOUT_EN.
module tb_keypad_entry;

    logic       clock;
    logic       clear_n;
    logic       btn_zero;
    logic       btn_one;
    logic       btn_submit;
    logic       btn_cancel;
    logic [3:0] password_input;
    logic       enter;
    logic [2:0] digit_count;
    logic       entry_error;
    logic       busy;

    typedef struct {
        bit         is_enter;
        logic [3:0] code;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;
    int   busy_cycles;
    bit   prev_enter;
    bit   prev_err;

    keypad_entry #(
        .DEBOUNCE_CYCLES(4),
        .ENTRY_TIMEOUT(50),
        .CODE_BITS(4),
        .LOCKOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .clear_n(clear_n),
        .btn_zero(btn_zero),
        .btn_one(btn_one),
        .btn_submit(btn_submit),
        .btn_cancel(btn_cancel),
        .password_input(password_input),
        .enter(enter),
        .digit_count(digit_count),
        .entry_error(entry_error),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // 0=zero 1=one 2=submit 3=cancel
    task automatic set_btn(input int which, input logic v);
        case (which)
            0: btn_zero = v;
            1: btn_one = v;
            2: btn_submit = v;
            default: btn_cancel = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        repeat (10) @(negedge clock);
        set_btn(which, 1'b0);
        repeat (10) @(negedge clock);
    endtask

    task automatic push(input bit is_enter, input logic [3:0] code);
        exp_t e;
        e.is_enter = is_enter;
        e.code = code;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expected response
    always @(negedge clock) begin
        if (clear_n) begin
            if (enter && entry_error) begin
                n_chk++;
                n_fail++;
                $display("FAIL both_strobes: enter=1 entry_error=1 required not both");
            end
            if ((enter && prev_enter) || (entry_error && prev_err)) begin
                n_chk++;
                n_fail++;
                $display("FAIL pulse_width: strobe high 2 cycles, required 1");
            end
            if (enter || entry_error) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: enter=%0d err=%0d none expected",
                             enter, entry_error);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_chk++;
                    if (enter !== e.is_enter ||
                        (e.is_enter && password_input !== e.code)) begin
                        n_fail++;
                        $display("FAIL strobe: enter=%0d code=%b, required enter=%0d code=%b",
                                 enter, password_input, e.is_enter, e.code);
                    end
                end
            end
        end
        prev_enter = enter;
        prev_err = entry_error;
        if (busy === 1'b1) busy_cycles++;
    end

    initial begin
        int k_first;
        n_chk = 0;
        n_fail = 0;
        busy_cycles = 0;
        btn_zero = 0;
        btn_one = 0;
        btn_submit = 0;
        btn_cancel = 0;
        clear_n = 0;
        repeat (3) @(negedge clock);
        chk("rst_pw", int'(password_input), 0);
        chk("rst_dc", int'(digit_count), 0);
        chk("rst_enter", int'(enter), 0);
        chk("rst_err", int'(entry_error), 0);
        chk("rst_busy", int'(busy), 0);
        clear_n = 1;
        repeat (2) @(negedge clock);

        // 1: valid code 1010
        press(1); press(0); press(1); press(0);
        chk("t1_dc4", int'(digit_count), 4);
        push(1, 4'b1010);
        press(2);
        chk("t1_dc0", int'(digit_count), 0);

        // 2: bouncing one, then stable high
        for (int t = 0; t < 10; t++) begin
            btn_one = (t % 2 == 0);
            repeat (2) @(negedge clock);
        end
        btn_one = 1;
        k_first = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k_first < 0 && digit_count == 3'd1) k_first = k;
        end
        chk("t2_latency", k_first, 7);
        btn_one = 0;
        repeat (10) @(negedge clock);
        chk("t2_dc1", int'(digit_count), 1);
        press(3);
        chk("t2_cancel_dc0", int'(digit_count), 0);

        // 3: short submit
        press(1); press(1);
        push(0, 4'b0000);
        press(2);
        chk("t3_dc0", int'(digit_count), 0);
        chk("t3_pw_hold", int'(password_input), 4'b1010);

        // 4: fifth bit ignored, then timeout
        press(1); press(1); press(0); press(0); press(0);
        chk("t4_dc_sat", int'(digit_count), 4);
        push(1, 4'b1100);
        press(2);
        chk("t4_pw", int'(password_input), 4'b1100);
        press(1); press(0);
        chk("t4_dc2", int'(digit_count), 2);
        push(0, 4'b0000);
        repeat (60) @(negedge clock);
        chk("t4_to_dc0", int'(digit_count), 0);

        // 5: cancel beats one in the same cycle, then async reset mid-entry
        press(1); press(1); press(0);
        chk("t5_dc3", int'(digit_count), 3);
        btn_cancel = 1;
        btn_one = 1;
        repeat (10) @(negedge clock);
        btn_cancel = 0;
        btn_one = 0;
        repeat (10) @(negedge clock);
        chk("t5_cancel_dc0", int'(digit_count), 0);
        press(1); press(1);
        @(posedge clock);
        #2 clear_n = 0;
        #1;
        chk("t5_arst_dc", int'(digit_count), 0);
        chk("t5_arst_pw", int'(password_input), 0);
        chk("t5_arst_strobes", int'({enter, entry_error, busy}), 0);
        repeat (3) @(negedge clock);
        clear_n = 1;
        repeat (30) @(negedge clock);
        chk("t5_post_dc", int'(digit_count), 0);

        // 6: bit event lands 3 cycles after submit is acted on
        press(1); press(0); press(0); press(1);
        push(1, 4'b1001);
        busy_cycles = 0;
        btn_submit = 1;
        repeat (3) @(negedge clock);
        btn_one = 1;
        repeat (10) @(negedge clock);
        btn_submit = 0;
        btn_one = 0;
        repeat (20) @(negedge clock);
`ifdef KEY_LOCKOUT_EN
        chk("t6_busy_len", busy_cycles, 8);
        chk("t6_dc_ignored", int'(digit_count), 0);
`else
        chk("t6_busy_len", busy_cycles, 0);
        chk("t6_dc_accepted", int'(digit_count), 1);
`endif
        press(3);
        chk("t6_dc0", int'(digit_count), 0);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        chk("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
